// File: rtl/an_barrett_decoder_pipe_pkg.sv
// rtl/an_barrett_decoder_pipe_pkg.sv - AN-code constants, decode classes and table helpers
// Purpose: default code parameters plus constant functions that build the
//   Barrett multiplier, the largest legal codeword and the per-bit residue and
//   quotient-offset tables used by the single-bit corrector.
// Ports: none (package).
package an_code_pkg;

  localparam int AN_A    = 13;
  localparam int AN_K    = 3;
  localparam int AN_CW   = 7;
  localparam int AN_CNTW = 16;

  typedef enum logic [1:0] {
    DEC_CLEAN     = 2'd0,
    DEC_CORRECTED = 2'd1,
    DEC_UNCORR    = 2'd2
  } dec_kind_t;

  // floor(2^(2*cw) / a)
  function automatic longint an_mu(input int a, input int cw);
    return (longint'(1) << (2 * cw)) / longint'(a);
  endfunction

  // Largest legal codeword a*(2^k-1)
  function automatic int an_max_cw(input int a, input int k);
    return a * ((1 << k) - 1);
  endfunction

  // POS_RES[i] = 2^i mod a
  function automatic int an_pos_res(input int a, input int i);
    return int'((longint'(1) << i) % longint'(a));
  endfunction

  // NEG_RES[i] = (-2^i) mod a
  function automatic int an_neg_res(input int a, input int i);
    return (a - an_pos_res(a, i)) % a;
  endfunction

  // Clearing bit i of x = q*a + POS_RES[i] gives (q - POS_QOFF[i]) * a
  function automatic int an_pos_qoff(input int a, input int i);
    return int'((longint'(1) << i) / longint'(a));
  endfunction

  // Setting bit i of x = q*a + NEG_RES[i] gives (q + NEG_QOFF[i]) * a
  function automatic int an_neg_qoff(input int a, input int i);
    return int'(((longint'(1) << i) + longint'(an_neg_res(a, i))) / longint'(a));
  endfunction

endpackage

// File: rtl/an_barrett_decoder_pipe_if.sv
// rtl/an_barrett_decoder_pipe_if.sv - valid/ready bus of the AN-code decoder
// Purpose: groups the codeword input stream and the decoded result stream.
// Ports: in_valid/in_ready/in_data (codeword), out_valid/out_ready/out_msg,
//   out_corrected/out_uncorr (result). master = producer/consumer side,
//   slave = decoder side.
interface an_barrett_decoder_pipe_if import an_code_pkg::*; #(
  parameter int CW = AN_CW,
  parameter int K  = AN_K
) ();
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [K-1:0]  out_msg;
  logic          out_corrected;
  logic          out_uncorr;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_msg, out_corrected, out_uncorr
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_msg, out_corrected, out_uncorr
  );
endinterface

// File: rtl/an_barrett_reduce.sv
// rtl/an_barrett_reduce.sv - two-stage Barrett reduction of a codeword by A
// Purpose: S1 registers x and the high part of x*MU; S2 forms q0 and r0,
//   applies the single conditional correction and registers q, r and x.
// Ports: clk; en (advance both stages); x (codeword in);
//   x_out (codeword delayed 2 stages); q (quotient); r (residue, 0..A-1).
module an_barrett_reduce import an_code_pkg::*; #(
  parameter int A  = AN_A,
  parameter int CW = AN_CW,
  parameter int RW = $clog2(AN_A)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [CW-1:0] x,
  output logic [CW-1:0] x_out,
  output logic [CW-1:0] q,
  output logic [RW-1:0] r
);
  localparam logic [2*CW-1:0] MU = (2*CW)'(an_mu(A, CW));
  localparam logic [CW-1:0]   AC = CW'(A);

  logic [CW-1:0] x1;
  logic [CW-1:0] p_hi;   // P >> 2*CW; the low bits of P are never consumed
  logic [CW-1:0] q_a;
  logic [CW-1:0] r0;
  logic          ge;

  always_ff @(posedge clk) begin
    if (en) begin
      x1   <= x;
      p_hi <= CW'(({{(2*CW){1'b0}}, x} * {{CW{1'b0}}, MU}) >> (2*CW));
    end
  end

  // MU rounds down, so q0 undershoots floor(x/A) by at most one and r0 < 2A.
  always_comb begin
    q_a = p_hi * AC;
    r0  = x1 - q_a;
    ge  = (r0 >= AC);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      x_out <= x1;
      q     <= p_hi + CW'(ge);
      r     <= ge ? RW'(r0 - AC) : RW'(r0);
    end
  end
endmodule

// File: rtl/an_barrett_decoder_pipe.sv
// rtl/an_barrett_decoder_pipe.sv - pipelined AN-code decoder with single-bit correction
// Purpose: 3-stage decoder; stages 1-2 are the Barrett reducer, stage 3 picks
//   the clean / corrected / uncorrectable result. Saturating status counters.
// Ports: clk, rst (sync, active high); bus (slave: codeword in, result out);
//   cnt_clr (clear both counters); corr_cnt, uncorr_cnt (accepted flagged outputs).
module an_barrett_decoder_pipe import an_code_pkg::*; #(
  parameter int A    = AN_A,
  parameter int K    = AN_K,
  parameter int CW   = AN_CW,
  parameter int CNTW = AN_CNTW
) (
  input  logic                     clk,
  input  logic                     rst,
  an_barrett_decoder_pipe_if.slave bus,
  input  logic                     cnt_clr,
  output logic [CNTW-1:0]          corr_cnt,
  output logic [CNTW-1:0]          uncorr_cnt
);
  localparam int            RW      = $clog2(A);
  localparam logic [CW:0]   MAX_X   = (CW+1)'(an_max_cw(A, K));
  localparam logic [CW-1:0] MSG_MAX = CW'((1 << K) - 1);

  logic          adv;
  logic          v1, v2;
  logic [CW-1:0] x2, q2;
  logic [RW-1:0] r2;
  logic          xfer;

  // Whole pipeline moves together whenever the output register can take a word.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign xfer         = bus.out_valid && bus.out_ready;

  an_barrett_reduce #(.A(A), .CW(CW), .RW(RW)) u_reduce (
    .clk   (clk),
    .en    (adv),
    .x     (bus.in_data),
    .x_out (x2),
    .q     (q2),
    .r     (r2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      v2 <= v1;
    end
  end

  // One flip candidate per bit position, each with its own constant residue
  // and quotient offset, so the corrected message needs no divider.
  logic [CW:0]   x2e;
  logic [CW-1:0] pos_hit, neg_hit;
  logic [K-1:0]  pos_msg [CW];
  logic [K-1:0]  neg_msg [CW];

  assign x2e = {1'b0, x2};

  for (genvar g = 0; g < CW; g++) begin : g_cand
    localparam logic [RW-1:0] PR  = RW'(an_pos_res(A, g));
    localparam logic [RW-1:0] NR  = RW'(an_neg_res(A, g));
    localparam logic [CW-1:0] PQ  = CW'(an_pos_qoff(A, g));
    localparam logic [CW-1:0] NQ  = CW'(an_neg_qoff(A, g));
    localparam logic [CW:0]   BIT = (CW+1)'(1) << g;
    assign pos_hit[g] = (r2 == PR) &&  x2[g] && ((x2e - BIT) <= MAX_X);
    assign neg_hit[g] = (r2 == NR) && !x2[g] && ((x2e + BIT) <= MAX_X);
    assign pos_msg[g] = K'(q2 - PQ);
    assign neg_msg[g] = K'(q2 + NQ);
  end

  dec_kind_t    kind;
  logic [K-1:0] msg_d;
  logic [K-1:0] cand_msg;
  int           n_hits;

  always_comb begin
    n_hits   = 0;
    cand_msg = '0;
    for (int i = 0; i < CW; i++) begin
      if (pos_hit[i]) begin
        n_hits   = n_hits + 1;
        cand_msg = pos_msg[i];
      end
      if (neg_hit[i]) begin
        n_hits   = n_hits + 1;
        cand_msg = neg_msg[i];
      end
    end
    msg_d = q2[K-1:0];
    kind  = DEC_UNCORR;
    if (r2 == '0) begin
      kind = (q2 <= MSG_MAX) ? DEC_CLEAN : DEC_UNCORR;
    end else if (n_hits == 1) begin
      kind  = DEC_CORRECTED;
      msg_d = cand_msg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.out_msg       <= '0;
      bus.out_corrected <= 1'b0;
      bus.out_uncorr    <= 1'b0;
    end else if (adv) begin
      bus.out_valid     <= v2;
      bus.out_msg       <= msg_d;
      bus.out_corrected <= v2 && (kind == DEC_CORRECTED);
      bus.out_uncorr    <= v2 && (kind == DEC_UNCORR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (xfer) begin
      if (bus.out_corrected && (corr_cnt != '1))
        corr_cnt <= corr_cnt + CNTW'(1);
      if (bus.out_uncorr && (uncorr_cnt != '1))
        uncorr_cnt <= uncorr_cnt + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_an_barrett_decoder_pipe.sv
// tb/tb_an_barrett_decoder_pipe.sv - self-checking bench for an_barrett_decoder_pipe
module tb_an_barrett_decoder_pipe;
  localparam int A = 13, K = 3, CW = 7, CNTW = 16, MAXX = 91;

  logic            clk = 1'b0;
  logic            rst;
  logic            cnt_clr;
  logic [CNTW-1:0] corr_cnt, uncorr_cnt;
  int              errors = 0;
  int              checks = 0;
  bit              rand_bp = 0;
  int              exp_corr, exp_uncorr;
  int              send_cycles;

  typedef struct packed {
    logic [K-1:0] msg;
    logic         corr;
    logic         uncorr;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];

  always #5 clk = ~clk;

  an_barrett_decoder_pipe_if #(.CW(CW), .K(K)) bus ();

  an_barrett_decoder_pipe #(.A(A), .K(K), .CW(CW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  // Record every output transfer; inputs only change just after posedge.
  always @(negedge clk)
    if (bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_msg, bus.out_corrected, bus.out_uncorr});

  // Reference decoder: exact division, plus brute-force search over all
  // single-bit flips for a legal codeword.
  function automatic res_t model(input int x);
    res_t res;
    int hits = 0;
    int fixed = 0;
    res.msg = K'((x / A) % (1 << K));
    res.corr = 1'b0;
    res.uncorr = 1'b0;
    if (x % A == 0) begin
      if (x / A > (1 << K) - 1) res.uncorr = 1'b1;
      return res;
    end
    for (int i = 0; i < CW; i++) begin
      int y = x ^ (1 << i);
      if ((y % A == 0) && (y <= MAXX)) begin
        hits++;
        fixed = y / A;
      end
    end
    if (hits == 1) begin
      res.msg = K'(fixed);
      res.corr = 1'b1;
    end else begin
      res.uncorr = 1'b1;
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int x);
    bit acc = 0;
    res_t m;
    bus.in_valid = 1'b1;
    bus.in_data  = CW'(x);
    for (int n = 0; n < 200 && !acc; n++) begin
      if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = bus.in_ready;
      tick();
      send_cycles++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout x=%0d in_ready stayed 0, required accept", x);
    end
    m = model(x);
    exp_q.push_back(m);
    if (m.corr) exp_corr++;
    if (m.uncorr) exp_uncorr++;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 2000 && got_q.size() < exp_q.size(); n++) begin
      if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_corr = 0;
    exp_uncorr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if ({bus.out_msg, bus.out_corrected, bus.out_uncorr} !== '0) begin errors++;
      $display("FAIL reset_outputs got msg=%0d c=%b u=%b want 0", bus.out_msg, bus.out_corrected, bus.out_uncorr); end
    checks++; if (corr_cnt !== 0 || uncorr_cnt !== 0) begin errors++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
  endtask

  // Latency counted in rising edges, the accept edge being the first.
  task automatic test_latency();
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = CW'(65);
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL latency got=%0d edges want=3", n); end
    checks++; if (bus.out_msg !== 3'd5 || bus.out_corrected || bus.out_uncorr) begin errors++;
      $display("FAIL latency_word65 got msg=%0d c=%b u=%b want msg=5 c=0 u=0", bus.out_msg, bus.out_corrected, bus.out_uncorr); end
    tick();
    tick();
    got_q.delete();
  endtask

  task automatic test_directed();
    int    xs[6]   = '{65, 67, 7, 64, 127, 117};
    int    msgs[6] = '{5, 5, 3, 4, 1, 1};
    bit    cs[6]   = '{0, 1, 1, 0, 0, 0};
    bit    us[6]   = '{0, 0, 0, 1, 1, 1};
    rand_bp = 0;
    bus.out_ready = 1'b1;
    clear_counters();
    send_cycles = 0;
    foreach (xs[i]) send_word(xs[i]);
    checks++; if (send_cycles !== 6) begin errors++; $display("FAIL throughput got=%0d cycles want=6", send_cycles); end
    wait_drain();
    checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL directed_count got=%0d want=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== res_t'({K'(msgs[i]), cs[i], us[i]})) begin errors++;
        $display("FAIL directed x=%0d got msg=%0d c=%b u=%b want msg=%0d c=%b u=%b",
                 xs[i], got_q[i].msg, got_q[i].corr, got_q[i].uncorr, msgs[i], cs[i], us[i]); end
    end
    checks++; if (corr_cnt !== 2 || uncorr_cnt !== 3) begin errors++;
      $display("FAIL directed_counters got %0d/%0d want 2/3", corr_cnt, uncorr_cnt); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    rand_bp = 1;
    clear_counters();
    for (int i = 0; i < 80; i++) send_word(int'($urandom_range(0, 127)));
    wait_drain();
    rand_bp = 0;
    checks++; if (got_q.size() !== exp_q.size()) begin errors++;
      $display("FAIL random_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL random_word %0d got msg=%0d c=%b u=%b want msg=%0d c=%b u=%b", i,
                 got_q[i].msg, got_q[i].corr, got_q[i].uncorr, exp_q[i].msg, exp_q[i].corr, exp_q[i].uncorr); end
    end
    checks++; if (corr_cnt !== CNTW'(exp_corr) || uncorr_cnt !== CNTW'(exp_uncorr)) begin errors++;
      $display("FAIL random_counters got %0d/%0d want %0d/%0d", corr_cnt, uncorr_cnt, exp_corr, exp_uncorr); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    bit held_bad = 0;
    bit acc;
    rand_bp = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = CW'(13 * (idx + 1));
      #1;
      acc = bus.in_ready;
      if (bus.out_valid && bus.out_msg !== 3'd1) held_bad = 1;
      tick();
      if (acc) begin
        exp_q.push_back(model(13 * (idx + 1)));
        idx++;
      end
    end
    checks++; if (idx !== 3) begin errors++; $display("FAIL bp_accepts got=%0d want=3", idx); end
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL bp_stall got in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid); end
    checks++; if (held_bad) begin errors++; $display("FAIL bp_hold out_msg changed while stalled, want 1"); end
    bus.out_ready = 1'b1;
    for (int i = idx; i < 5; i++) send_word(13 * (i + 1));
    wait_drain();
    checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL bp_count got=%0d want=5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== res_t'({K'(i + 1), 1'b0, 1'b0})) begin errors++;
        $display("FAIL bp_order %0d got msg=%0d c=%b u=%b want msg=%0d c=0 u=0",
                 i, got_q[i].msg, got_q[i].corr, got_q[i].uncorr, i + 1); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_cnt_clr();
    int n = 0;
    clear_counters();
    bus.out_ready = 1'b0;
    send_word(67);
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    bus.out_ready = 1'b1;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (got_q.size() !== 1 || got_q[0].corr !== 1'b1) begin errors++;
      $display("FAIL clr_transfer got count=%0d want one corrected transfer", got_q.size()); end
    checks++; if (corr_cnt !== 0) begin errors++; $display("FAIL clr_wins got corr_cnt=%0d want 0", corr_cnt); end
    exp_q.delete(); got_q.delete();
    send_word(67);
    wait_drain();
    checks++; if (corr_cnt !== 1 || uncorr_cnt !== 0) begin errors++;
      $display("FAIL clr_then_count got %0d/%0d want 1/0", corr_cnt, uncorr_cnt); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midstream();
    bit seen = 0;
    bus.out_ready = 1'b0;
    send_word(7);
    send_word(64);
    send_word(13);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) seen = 1;
      tick();
    end
    checks++; if (seen || got_q.size() !== 0) begin errors++;
      $display("FAIL midreset_flush got out_valid seen=%b transfers=%0d want none", seen, got_q.size()); end
    checks++; if (corr_cnt !== 0 || uncorr_cnt !== 0) begin errors++;
      $display("FAIL midreset_counters got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    exp_corr = 0;
    exp_uncorr = 0;
    send_cycles = 0;
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_cnt_clr();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
